// File: rtl/cnl_scheduler.sv
// Channel scheduler: round-robin choice among three byte FIFOs that hold a full
// packet, with empty-packet fallback and per-channel grant statistics.
module cnl_scheduler #(
    parameter int unsigned PKT_BYTES = 30,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] fifo_1_cnt,
    input  logic [CNT_W-1:0] fifo_2_cnt,
    input  logic [CNT_W-1:0] fifo_3_cnt,
    input  logic             next,
    output logic             start,
    output logic [1:0]       rdy_cnl,
    output logic [15:0]      pkt_cnt_1,
    output logic [15:0]      pkt_cnt_2,
    output logic [15:0]      pkt_cnt_3,
    output logic [15:0]      empty_cnt
);

    localparam int unsigned CMP_W = (CNT_W > 32) ? CNT_W : 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARB  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       start_nxt;
    logic [1:0] rdy_nxt;
    logic       grant;
    logic [1:0] last_grant;
    logic [1:0] arb;
    logic [2:0] elig;

    // Widened compare so a PKT_BYTES larger than the counter range is never truncated
    assign elig[0] = CMP_W'(fifo_1_cnt) >= CMP_W'(PKT_BYTES);
    assign elig[1] = CMP_W'(fifo_2_cnt) >= CMP_W'(PKT_BYTES);
    assign elig[2] = CMP_W'(fifo_3_cnt) >= CMP_W'(PKT_BYTES);

    // Round-robin search beginning after the last data grant
    always_comb begin
        arb = 2'd0;
        case (last_grant)
            2'd1: begin
                if (elig[1])      arb = 2'd2;
                else if (elig[2]) arb = 2'd3;
                else if (elig[0]) arb = 2'd1;
            end
            2'd2: begin
                if (elig[2])      arb = 2'd3;
                else if (elig[0]) arb = 2'd1;
                else if (elig[1]) arb = 2'd2;
            end
            default: begin
                if (elig[0])      arb = 2'd1;
                else if (elig[1]) arb = 2'd2;
                else if (elig[2]) arb = 2'd3;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        start_nxt = start;
        rdy_nxt   = rdy_cnl;
        grant     = 1'b0;
        case (state)
            ST_IDLE: begin
                start_nxt = 1'b0;
                if (enable) state_nxt = ST_ARB;
            end
            ST_ARB: begin
                grant     = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Disable is honoured only at a packet boundary
                if (next) begin
                    if (enable) begin
                        grant = 1'b1;
                    end else begin
                        start_nxt = 1'b0;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                start_nxt = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
        if (grant) begin
            rdy_nxt   = arb;
            start_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            start      <= 1'b0;
            rdy_cnl    <= 2'd0;
            last_grant <= 2'd3;
            pkt_cnt_1  <= 16'd0;
            pkt_cnt_2  <= 16'd0;
            pkt_cnt_3  <= 16'd0;
            empty_cnt  <= 16'd0;
        end else begin
            state   <= state_nxt;
            start   <= start_nxt;
            rdy_cnl <= rdy_nxt;
            if (grant) begin
                if (arb != 2'd0) last_grant <= arb;
                case (arb)
                    2'd1:    pkt_cnt_1 <= pkt_cnt_1 + 16'd1;
                    2'd2:    pkt_cnt_2 <= pkt_cnt_2 + 16'd1;
                    2'd3:    pkt_cnt_3 <= pkt_cnt_3 + 16'd1;
                    default: empty_cnt <= empty_cnt + 16'd1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnl_scheduler.sv
// Directed bench for cnl_scheduler: per-cycle vector table plus sequences for
// periodic round-robin, mid-packet reset and counter wrap-around.
module tb_cnl_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  fifo_1_cnt;
    logic [7:0]  fifo_2_cnt;
    logic [7:0]  fifo_3_cnt;
    logic        next;
    logic        start;
    logic [1:0]  rdy_cnl;
    logic [15:0] pkt_cnt_1;
    logic [15:0] pkt_cnt_2;
    logic [15:0] pkt_cnt_3;
    logic [15:0] empty_cnt;

    int checks = 0;
    int errors = 0;

    cnl_scheduler #(.PKT_BYTES(30), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_1_cnt (fifo_1_cnt),
        .fifo_2_cnt (fifo_2_cnt),
        .fifo_3_cnt (fifo_3_cnt),
        .next       (next),
        .start      (start),
        .rdy_cnl    (rdy_cnl),
        .pkt_cnt_1  (pkt_cnt_1),
        .pkt_cnt_2  (pkt_cnt_2),
        .pkt_cnt_3  (pkt_cnt_3),
        .empty_cnt  (empty_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        nx;
        logic [7:0]  f1;
        logic [7:0]  f2;
        logic [7:0]  f3;
        logic        st;
        logic [1:0]  rdy;
        logic [15:0] c1;
        logic [15:0] c2;
        logic [15:0] c3;
        logic [15:0] ce;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; next = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_cnt(input string nm, input logic [15:0] c1, input logic [15:0] c2,
                           input logic [15:0] c3, input logic [15:0] ce);
        chk({nm, ".pkt1"}, 32'(pkt_cnt_1), 32'(c1));
        chk({nm, ".pkt2"}, 32'(pkt_cnt_2), 32'(c2));
        chk({nm, ".pkt3"}, 32'(pkt_cnt_3), 32'(c3));
        chk({nm, ".empty"}, 32'(empty_cnt), 32'(ce));
    endtask

    int exp_seq[5] = '{2, 3, 1, 2, 3};

    initial begin
        // en nx f1 f2 f3 | start rdy | c1 c2 c3 empty (values after the edge)
        tbl[0]  = '{1'b1, 1'b0, 8'd30, 8'd30, 8'd30,  1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'd30, 8'd30, 8'd30,  1'b1, 2'd1, 16'd1, 16'd0, 16'd0, 16'd0};
        tbl[2]  = '{1'b1, 1'b0, 8'd30, 8'd30, 8'd30,  1'b1, 2'd1, 16'd1, 16'd0, 16'd0, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'd30, 8'd30, 8'd30,  1'b1, 2'd2, 16'd1, 16'd1, 16'd0, 16'd0};
        tbl[4]  = '{1'b1, 1'b1, 8'd30, 8'd30, 8'd30,  1'b1, 2'd3, 16'd1, 16'd1, 16'd1, 16'd0};
        tbl[5]  = '{1'b1, 1'b1, 8'd30, 8'd30, 8'd30,  1'b1, 2'd1, 16'd2, 16'd1, 16'd1, 16'd0};
        tbl[6]  = '{1'b1, 1'b0, 8'd29, 8'd30, 8'd255, 1'b1, 2'd1, 16'd2, 16'd1, 16'd1, 16'd0};
        tbl[7]  = '{1'b1, 1'b1, 8'd29, 8'd30, 8'd255, 1'b1, 2'd2, 16'd2, 16'd2, 16'd1, 16'd0};
        tbl[8]  = '{1'b1, 1'b1, 8'd29, 8'd30, 8'd255, 1'b1, 2'd3, 16'd2, 16'd2, 16'd2, 16'd0};
        tbl[9]  = '{1'b1, 1'b1, 8'd29, 8'd30, 8'd29,  1'b1, 2'd2, 16'd2, 16'd3, 16'd2, 16'd0};
        tbl[10] = '{1'b1, 1'b1, 8'd0,  8'd0,  8'd0,   1'b1, 2'd0, 16'd2, 16'd3, 16'd2, 16'd1};
        tbl[11] = '{1'b1, 1'b1, 8'd0,  8'd0,  8'd0,   1'b1, 2'd0, 16'd2, 16'd3, 16'd2, 16'd2};
        tbl[12] = '{1'b1, 1'b1, 8'd0,  8'd30, 8'd0,   1'b1, 2'd2, 16'd2, 16'd4, 16'd2, 16'd2};
        tbl[13] = '{1'b0, 1'b0, 8'd30, 8'd30, 8'd30,  1'b1, 2'd2, 16'd2, 16'd4, 16'd2, 16'd2};
        tbl[14] = '{1'b0, 1'b1, 8'd30, 8'd30, 8'd30,  1'b0, 2'd2, 16'd2, 16'd4, 16'd2, 16'd2};
        tbl[15] = '{1'b0, 1'b1, 8'd30, 8'd30, 8'd30,  1'b0, 2'd2, 16'd2, 16'd4, 16'd2, 16'd2};
        tbl[16] = '{1'b1, 1'b1, 8'd30, 8'd30, 8'd30,  1'b0, 2'd2, 16'd2, 16'd4, 16'd2, 16'd2};
        tbl[17] = '{1'b1, 1'b1, 8'd30, 8'd30, 8'd30,  1'b1, 2'd3, 16'd2, 16'd4, 16'd3, 16'd2};
        tbl[18] = '{1'b1, 1'b0, 8'd30, 8'd30, 8'd30,  1'b1, 2'd3, 16'd2, 16'd4, 16'd3, 16'd2};

        fifo_1_cnt = 8'd0; fifo_2_cnt = 8'd0; fifo_3_cnt = 8'd0;
        do_reset();
        chk("reset.start", 32'(start), 32'd0);
        chk("reset.rdy", 32'(rdy_cnl), 32'd0);
        chk_cnt("reset", 16'd0, 16'd0, 16'd0, 16'd0);

        for (int i = 0; i < 19; i++) begin
            enable = tbl[i].en; next = tbl[i].nx;
            fifo_1_cnt = tbl[i].f1; fifo_2_cnt = tbl[i].f2; fifo_3_cnt = tbl[i].f3;
            step();
            chk($sformatf("tbl[%0d].start", i), 32'(start), 32'(tbl[i].st));
            chk($sformatf("tbl[%0d].rdy", i), 32'(rdy_cnl), 32'(tbl[i].rdy));
            chk_cnt($sformatf("tbl[%0d]", i), tbl[i].c1, tbl[i].c2, tbl[i].c3, tbl[i].ce);
        end

        // Periodic next every 40 cycles with all channels eligible
        do_reset();
        fifo_1_cnt = 8'd30; fifo_2_cnt = 8'd30; fifo_3_cnt = 8'd30;
        enable = 1'b1; next = 1'b0;
        step();
        chk("rr.arb_start", 32'(start), 32'd0);
        step();
        chk("rr.grant0", 32'(rdy_cnl), 32'd1);
        for (int p = 0; p < 5; p++) begin
            repeat (39) step();
            chk($sformatf("rr.hold%0d", p), 32'(rdy_cnl), (p == 0) ? 32'd1 : 32'(exp_seq[p-1]));
            next = 1'b1;
            step();
            next = 1'b0;
            chk($sformatf("rr.grant%0d", p + 1), 32'(rdy_cnl), 32'(exp_seq[p]));
        end
        chk_cnt("rr.end", 16'd2, 16'd2, 16'd2, 16'd0);

        // Reset mid-packet with rdy_cnl=2; reset beats enable and next
        do_reset();
        enable = 1'b1;
        step();
        step();
        next = 1'b1;
        step();
        next = 1'b0;
        chk("mid.pre_rdy", 32'(rdy_cnl), 32'd2);
        rst = 1'b1; next = 1'b1;
        step();
        chk("mid.start", 32'(start), 32'd0);
        chk("mid.rdy", 32'(rdy_cnl), 32'd0);
        chk_cnt("mid", 16'd0, 16'd0, 16'd0, 16'd0);
        rst = 1'b0; next = 1'b0;
        step();
        chk("mid.arb_start", 32'(start), 32'd0);
        step();
        chk("mid.first_rdy", 32'(rdy_cnl), 32'd1);
        chk_cnt("mid.first", 16'd1, 16'd0, 16'd0, 16'd0);

        // Drive pkt_cnt_1 through 16'hFFFF and wrap to zero
        do_reset();
        fifo_1_cnt = 8'd30; fifo_2_cnt = 8'd0; fifo_3_cnt = 8'd0;
        enable = 1'b1; next = 1'b1;
        step();
        step();
        chk("wrap.first", 32'(pkt_cnt_1), 32'd1);
        repeat (65534) @(posedge clk);
        #1;
        chk_cnt("wrap.max", 16'hFFFF, 16'd0, 16'd0, 16'd0);
        step();
        chk_cnt("wrap.zero", 16'd0, 16'd0, 16'd0, 16'd0);
        chk("wrap.rdy", 32'(rdy_cnl), 32'd1);
        next = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
